// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes,
// ALU/mux select codes and the control word produced by the output decoder.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13,
        S_BNEBR   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // PC and IR enables are split into request bits; the top gates them with MemReady/Zero.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite_rdy;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen_always;
        logic       pcen_rdy;
        logic       pcen_zero;
        logic       pcen_nzero;
        logic       err;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational Moore output map: controller state to datapath control word.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.
module mips_mc_outdec
    import mips_mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: every field gets a default first, so no path through the case can infer a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb     = SRCB_FOUR;
                ctrl.aluop       = ALUOP_ADD;
                ctrl.irwrite_rdy = 1'b1;
                ctrl.pcen_rdy    = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH2;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_B;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.pcsrc     = PCSRC_ALUOUT;
                ctrl.pcen_zero = 1'b1;
            end
`ifdef MIPS_MC_BNE_EN
            S_BNEBR: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_B;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcen_nzero = 1'b1;
            end
`else
            S_BNEBR: ctrl = '0;
`endif
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JUMP: begin
                ctrl.pcsrc       = PCSRC_JUMP;
                ctrl.pcen_always = 1'b1;
            end
            S_ILLEGAL: ctrl.err = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath (Moore, stalls on MemReady).
// Define MIPS_MC_BNE_EN to decode bne; otherwise bne traps as an illegal opcode.
module mips_multicycle_controller
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Err
);

    state_t state;
    ctrl_t  ctrl;

    // NOTE: state is updated with <= so every reader in this edge sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state <= S_FETCH;
                S_FETCH:   if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
`ifdef MIPS_MC_BNE_EN
                        OP_BNE:       state <= S_BNEBR;
`else
                        OP_BNE:       state <= S_ILLEGAL;
`endif
                        default:      state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR:  state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (MemReady) state <= S_MEMWB;
                S_MEMWR:   if (MemReady) state <= S_FETCH;
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                S_ILLEGAL: state <= S_ILLEGAL;
`ifdef MIPS_MC_BNE_EN
                S_BNEBR:   state <= S_FETCH;
`endif
                // Single-cycle states, and any unused encoding, resume at FETCH.
                default:   state <= S_FETCH;
            endcase
        end
    end

    mips_mc_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    assign IorD     = ctrl.iord;
    assign MemWrite = ctrl.memwrite;
    assign IRWrite  = ctrl.irwrite_rdy & MemReady;
    assign RegDst   = ctrl.regdst;
    assign MemtoReg = ctrl.memtoreg;
    assign RegWrite = ctrl.regwrite;
    assign ALUSrcA  = ctrl.alusrca;
    assign ALUSrcB  = ctrl.alusrcb;
    assign ALUOp    = ctrl.aluop;
    assign PCSrc    = ctrl.pcsrc;
    assign PCEn     = ctrl.pcen_always
                    | (ctrl.pcen_rdy   & MemReady)
                    | (ctrl.pcen_zero  & Zero)
                    | (ctrl.pcen_nzero & ~Zero);
    assign Err      = ctrl.err;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed self-checking bench for mips_multicycle_controller.
// Expected control words are hand-written per state; bne behaviour follows MIPS_MC_BNE_EN.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Err;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;

    int checks = 0;
    int errors = 0;

    // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,Err}
    logic [14:0] obs;
    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, PCEn, Err};

    localparam logic [14:0] W_ZERO   = 15'b0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] W_FETCH  = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
    localparam logic [14:0] W_FSTALL = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [14:0] W_DECODE = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [14:0] W_MEMADR = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [14:0] W_MEMRD  = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] W_MEMWB  = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [14:0] W_MEMWR  = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] W_EXEC   = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [14:0] W_ALUWB  = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [14:0] W_BR_T   = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [14:0] W_BR_N   = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [14:0] W_ADDIWB = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [14:0] W_JUMP   = 15'b0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [14:0] W_ILL    = 15'b0_0_0_0_0_0_0_00_00_00_0_1;

    mips_multicycle_controller dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .Zero     (Zero),
        .MemReady (MemReady),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .Err      (Err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds rst across an edge, releases it, then expects IDLE followed by FETCH.
    task automatic test_reset();
        rst = 1'b1; MemReady = 1'b1; Zero = 1'b0; Op = 6'b000000;
        step();
        #1;
        checks++;
        if (obs !== W_ZERO) begin
            errors++; $display("FAIL reset_held: got %b expected %b", obs, W_ZERO);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== W_ZERO) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", obs, W_ZERO);
        end
        step();
        #1;
        checks++;
        if (obs !== W_FETCH) begin
            errors++; $display("FAIL reset_fetch: got %b expected %b", obs, W_FETCH);
        end
    endtask

    task automatic test_fetch_stall();
        logic        mr  [4];
        logic [14:0] exp [4];
        mr  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{W_FSTALL, W_FSTALL, W_FETCH, W_DECODE};
        Op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            MemReady = mr[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL fetch_stall step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
        // Finish the R-type that just decoded so the next test starts in FETCH.
        step(); step(); step();
        #1;
        checks++;
        if (obs !== W_FETCH) begin
            errors++; $display("FAIL fetch_stall_return: got %b expected %b", obs, W_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [14:0] exp [6];
        exp = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB, W_FETCH};
        Op = 6'b100011; MemReady = 1'b1; Zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL lw step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_sw_stall();
        logic        mr  [8];
        logic [14:0] exp [8];
        mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMWR, W_MEMWR, W_MEMWR, W_MEMWR, W_FETCH};
        Op = 6'b101011; Zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            MemReady = mr[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL sw_stall step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic        z   [7];
        logic [14:0] exp [7];
        z   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{W_FETCH, W_DECODE, W_BR_T, W_FETCH, W_DECODE, W_BR_N, W_FETCH};
        Op = 6'b000100; MemReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            Zero = z[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL beq step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
    endtask

    // R-type, addi and j issued back to back.
    task automatic test_back_to_back();
        logic [5:0]  op  [13];
        logic [14:0] exp [13];
        op  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                6'b001000, 6'b001000, 6'b001000, 6'b001000,
                6'b000010, 6'b000010, 6'b000010,
                6'b100011, 6'b100011};
        exp = '{W_FETCH, W_DECODE, W_EXEC, W_ALUWB,
                W_FETCH, W_DECODE, W_MEMADR, W_ADDIWB,
                W_FETCH, W_DECODE, W_JUMP,
                W_FETCH, W_DECODE};
        MemReady = 1'b1; Zero = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) step();
            Op = op[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
        // Let the lw that was started complete.
        step(); step(); step(); step();
        #1;
        checks++;
        if (obs !== W_FETCH) begin
            errors++; $display("FAIL back_to_back_return: got %b expected %b", obs, W_FETCH);
        end
    endtask

    // Reset asserted while a store is writing must drop MemWrite immediately.
    task automatic test_abort();
        Op = 6'b101011; MemReady = 1'b1; Zero = 1'b0;
        step(); step(); step();
        MemReady = 1'b0;
        #1;
        checks++;
        if (obs !== W_MEMWR) begin
            errors++; $display("FAIL abort_pre: got %b expected %b", obs, W_MEMWR);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== W_ZERO) begin
            errors++; $display("FAIL abort_async: got %b expected %b", obs, W_ZERO);
        end
        test_reset();
    endtask

    task automatic test_illegal();
        Op = 6'b111111; MemReady = 1'b1; Zero = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            MemReady = i[0];
            Zero     = i[1];
            #1;
            checks++;
            if (obs !== W_ILL) begin
                errors++; $display("FAIL illegal hold %0d: got %b expected %b", i, obs, W_ILL);
            end
            step();
        end
        test_reset();
    endtask

    task automatic test_bne();
        logic        z   [7];
        logic [14:0] exp [7];
`ifdef MIPS_MC_BNE_EN
        z   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp = '{W_FETCH, W_DECODE, W_BR_T, W_FETCH, W_DECODE, W_BR_N, W_FETCH};
`else
        z   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp = '{W_FETCH, W_DECODE, W_ILL, W_ILL, W_ILL, W_ILL, W_ILL};
`endif
        Op = 6'b000101; MemReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            Zero = z[i];
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL bne step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
        test_reset();
    endtask

    initial begin
        rst = 1'b1; Op = 6'b000000; Zero = 1'b0; MemReady = 1'b1;
        test_reset();
        test_fetch_stall();
        test_lw();
        test_sw_stall();
        test_beq();
        test_back_to_back();
        test_abort();
        test_illegal();
        test_bne();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
